// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the requesters and the register-file arbiter.
// The arbiter takes the slave modport; requesters drive through master.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3
);
  logic                   hold_i;
  logic [NREQ-1:0]        req_valid_i;
  logic [5*NREQ-1:0]      req_rd_i;
  logic [32*NREQ-1:0]     req_dat_i;
  logic [NREQ-1:0]        req_ready_o;
  logic                   wr_en_o;
  logic [4:0]             reg_des_o;
  logic [31:0]            reg_des_dat_o;
  logic [7:0]             drop_cnt_o;

  modport master (
    output hold_i, req_valid_i, req_rd_i, req_dat_i,
    input  req_ready_o, wr_en_o, reg_des_o, reg_des_dat_o, drop_cnt_o
  );

  modport slave (
    input  hold_i, req_valid_i, req_rd_i, req_dat_i,
    output req_ready_o, wr_en_o, reg_des_o, reg_des_dat_o, drop_cnt_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: picks one of NREQ requesters per cycle and
// registers its write. Define WB_RR_EN for round-robin; otherwise fixed priority.
module regfile_wb_arbiter #(
  parameter int NREQ = 3
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [4:0]      sel_rd;
  logic [31:0]     sel_dat;
  int              sel;
  int              rank;
  int              best_rank;

  logic            wr_q;
  logic [4:0]      des_q;
  logic [31:0]     dat_q;
  logic [7:0]      drop_q;

`ifdef WB_RR_EN
  logic [PW-1:0]   ptr;
`endif

  // Winner is the valid requester with the smallest rank; rank is the distance
  // from ptr in round-robin mode and simply the index in fixed-priority mode.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    sel_rd    = '0;
    sel_dat   = '0;
    sel       = 0;
    rank      = 0;
    best_rank = NREQ;
    if (!rst && !bus.hold_i) begin
      for (int k = 0; k < NREQ; k++) begin
`ifdef WB_RR_EN
        rank = k - int'(ptr);
        if (rank < 0) rank = rank + NREQ;
`else
        rank = k;
`endif
        if (bus.req_valid_i[k] && rank < best_rank) begin
          best_rank = rank;
          sel       = k;
          grant_any = 1'b1;
          sel_rd    = bus.req_rd_i[5*k +: 5];
          sel_dat   = bus.req_dat_i[32*k +: 32];
        end
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      grant[k] = grant_any && (sel == k);
    end
  end

  assign bus.req_ready_o = grant;

  // Writes to x0 are consumed but never reach the register file; they only
  // bump the saturating drop counter. Destination/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= 1'b0;
      des_q  <= '0;
      dat_q  <= '0;
      drop_q <= '0;
    end else begin
      wr_q <= grant_any && (sel_rd != 5'd0);
      if (grant_any && (sel_rd != 5'd0)) begin
        des_q <= sel_rd;
        dat_q <= sel_dat;
      end
      if (grant_any && (sel_rd == 5'd0) && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

`ifdef WB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_any) begin
      if (sel == NREQ - 1) ptr <= '0;
      else                 ptr <= PW'(sel + 1);
    end
  end
`endif

  // Outputs are forced low while reset is high so a write registered just
  // before reset never pulses the register file.
  assign bus.wr_en_o       = wr_q & ~rst;
  assign bus.reg_des_o     = rst ? 5'd0  : des_q;
  assign bus.reg_des_dat_o = rst ? 32'd0 : dat_q;
  assign bus.drop_cnt_o    = rst ? 8'd0  : drop_q;

endmodule
